// File: rtl/core_pkg.sv
// Shared types and defaults for the 9-bit core's program-flow logic.
// Holds the sequencer state encoding and default PC / target-table widths.
package core_pkg;

   localparam int PC_W_DEF  = 10;
   localparam int LUT_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_HALT    = 2'd3
   } seq_state_t;

   // Wait-counter width; one bit minimum so MEM_LAT=1 still elaborates
   function automatic int wait_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch/jump target table: 2^LUT_W entries of PC_W bits, zero-initialised.
// Latency: combinational read; backpressure: none.
module branch_lut
   import core_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int LUT_W = LUT_W_DEF
) (
   input  logic [LUT_W-1:0] idx,
   output logic [PC_W-1:0]  target
);

   // Contents are owned by whoever programs the table (benches poke entries directly)
   logic [PC_W-1:0] core [2**LUT_W] = '{default: '0};

   assign target = core[idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / flow FSM: sequential, branch, jump, multi-cycle MemOp stall, halt and wrap fault.
// Latency: next PC visible one cycle after the deciding instruction; Commit is combinational; no backpressure.
module pc_sequencer
   import core_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int LUT_W   = LUT_W_DEF,
   parameter int MEM_LAT = 2,
   parameter int CYC_W   = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Branch,
   input  logic             Zero,
   input  logic             Jump,
   input  logic             MemOp,
   input  logic             Halt,
   input  logic [LUT_W-1:0] TargetIdx,
   output logic [PC_W-1:0]  Prog_Ctr,
   output logic             Commit,
   output logic             Done,
   output logic             Fault,
   output logic [CYC_W-1:0] CycleCnt
);

   localparam int                WAIT_W    = wait_width(MEM_LAT);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);
   localparam logic [PC_W-1:0]   PC_MAX    = '1;
   localparam logic [CYC_W-1:0]  CYC_MAX   = '1;

   seq_state_t        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic              done_q, done_d;
   logic              fault_q, fault_d;
   logic              commit;
   logic              advance;
   logic [PC_W-1:0]   lut_target;

   branch_lut #(
      .PC_W  (PC_W),
      .LUT_W (LUT_W)
   ) u_lut (
      .idx    (TargetIdx),
      .target (lut_target)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wait_d  = wait_q;
      cyc_d   = cyc_q;
      done_d  = done_q;
      fault_d = fault_q;
      commit  = 1'b0;
      advance = 1'b0;

      if ((state_q == ST_RUN || state_q == ST_MEMWAIT) && cyc_q != CYC_MAX) begin
         cyc_d = cyc_q + CYC_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (Start) begin
               state_d = ST_RUN;
               pc_d    = '0;
               cyc_d   = '0;
               done_d  = 1'b0;
               fault_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (Halt) begin
               state_d = ST_HALT;
               done_d  = 1'b1;
               commit  = 1'b1;
            end else if (MemOp && MEM_LAT > 1) begin
               state_d = ST_MEMWAIT;
               wait_d  = WAIT_INIT;
            end else if (Jump || (Branch && Zero)) begin
               pc_d   = lut_target;
               commit = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         ST_MEMWAIT: begin
            // The RUN cycle that issued the MemOp is the first of MEM_LAT cycles
            if (wait_q == WAIT_LAST) begin
               advance = 1'b1;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         commit = 1'b1;
         if (pc_q == PC_MAX) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
            fault_d = 1'b1;
         end else begin
            state_d = ST_RUN;
            pc_d    = pc_q + PC_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         wait_q  <= '0;
         cyc_q   <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wait_q  <= wait_d;
         cyc_q   <= cyc_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign Prog_Ctr = pc_q;
   assign Commit   = commit;
   assign Done     = done_q;
   assign Fault    = fault_q;
   assign CycleCnt = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized decoder traffic against a program-level model.
module tb_pc_sequencer;

   localparam int PC_W    = 10;
   localparam int LUT_W   = 5;
   localparam int MEM_LAT = 2;
   localparam int CYC_W   = 16;
   localparam int PC_TOP  = (1 << PC_W) - 1;
   localparam int CYC_TOP = (1 << CYC_W) - 1;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic             Start = 1'b0;
   logic             Branch = 1'b0;
   logic             Zero = 1'b0;
   logic             Jump = 1'b0;
   logic             MemOp = 1'b0;
   logic             Halt = 1'b0;
   logic [LUT_W-1:0] TargetIdx = '0;
   logic [PC_W-1:0]  Prog_Ctr;
   logic             Commit;
   logic             Done;
   logic             Fault;
   logic [CYC_W-1:0] CycleCnt;

   int checks = 0;
   int failures = 0;

   // Program-level model state (mode: 0 idle, 1 running, 2 waiting on memory, 3 halted)
   int m_mode, m_pc, m_left, m_cyc;
   bit m_done, m_fault;
   int m_lut [2**LUT_W];

   pc_sequencer #(
      .PC_W    (PC_W),
      .LUT_W   (LUT_W),
      .MEM_LAT (MEM_LAT),
      .CYC_W   (CYC_W)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Branch    (Branch),
      .Zero      (Zero),
      .Jump      (Jump),
      .MemOp     (MemOp),
      .Halt      (Halt),
      .TargetIdx (TargetIdx),
      .Prog_Ctr  (Prog_Ctr),
      .Commit    (Commit),
      .Done      (Done),
      .Fault     (Fault),
      .CycleCnt  (CycleCnt)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_flags();
      Start = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
      MemOp = 1'b0; Halt = 1'b0; TargetIdx = '0;
   endtask

   task automatic do_reset();
      clear_flags();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   task automatic restart_to(input int target);
      do_reset();
      Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 0; i < target; i++) step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #20;
      checks++; if (Prog_Ctr !== '0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", Prog_Ctr); end
      checks++; if (Commit !== 1'b0) begin failures++; $display("FAIL rst_commit got=%b exp=0", Commit); end
      checks++; if (Done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", Done); end
      checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", Fault); end
      checks++; if (CycleCnt !== '0) begin failures++; $display("FAIL rst_cyc got=%0d exp=0", CycleCnt); end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   task automatic test_sequential();
      Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         Start = (i == 3);  // Start while running must be ignored
         #1;
         checks++; if (Prog_Ctr !== PC_W'(i)) begin failures++; $display("FAIL seq_pc got=%0d exp=%0d", Prog_Ctr, i); end
         checks++; if (Commit !== 1'b1) begin failures++; $display("FAIL seq_commit got=%b exp=1 at pc %0d", Commit, i); end
         step();
      end
      Start = 1'b0;
      checks++; if (CycleCnt !== CYC_W'(6)) begin failures++; $display("FAIL seq_cyc got=%0d exp=6", CycleCnt); end
   endtask

   task automatic test_branch();
      for (int z = 1; z >= 0; z--) begin
         restart_to(2);
         dut.u_lut.core[3] = 10'd40;
         Branch = 1'b1; Zero = (z == 1); TargetIdx = 5'd3;
         #1;
         checks++; if (Commit !== 1'b1) begin failures++; $display("FAIL br_commit got=%b exp=1 zero=%0d", Commit, z); end
         step();
         clear_flags();
         checks++; if (Prog_Ctr !== PC_W'((z == 1) ? 40 : 3)) begin failures++; $display("FAIL br_pc got=%0d exp=%0d zero=%0d", Prog_Ctr, (z == 1) ? 40 : 3, z); end
      end
   endtask

   task automatic test_memop();
      restart_to(7);
      checks++; if (CycleCnt !== CYC_W'(7)) begin failures++; $display("FAIL mem_cyc_pre got=%0d exp=7", CycleCnt); end
      MemOp = 1'b1;
      #1;
      checks++; if (Commit !== 1'b0) begin failures++; $display("FAIL mem_commit0 got=%b exp=0", Commit); end
      step();
      // Decoder noise during the wait must have no effect
      Jump = 1'b1; TargetIdx = 5'd3; Halt = 1'b1;
      #1;
      checks++; if (Prog_Ctr !== 10'd7) begin failures++; $display("FAIL mem_pc_hold got=%0d exp=7", Prog_Ctr); end
      checks++; if (Commit !== 1'b1) begin failures++; $display("FAIL mem_commit1 got=%b exp=1", Commit); end
      step();
      clear_flags();
      checks++; if (Prog_Ctr !== 10'd8) begin failures++; $display("FAIL mem_pc_next got=%0d exp=8", Prog_Ctr); end
      checks++; if (CycleCnt !== CYC_W'(9)) begin failures++; $display("FAIL mem_cyc got=%0d exp=9", CycleCnt); end
   endtask

   task automatic test_halt_restart();
      restart_to(12);
      Halt = 1'b1;
      #1;
      checks++; if (Commit !== 1'b1) begin failures++; $display("FAIL halt_commit got=%b exp=1", Commit); end
      step();
      Halt = 1'b0;
      checks++; if (Done !== 1'b1) begin failures++; $display("FAIL halt_done got=%b exp=1", Done); end
      checks++; if (Prog_Ctr !== 10'd12) begin failures++; $display("FAIL halt_pc got=%0d exp=12", Prog_Ctr); end
      checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL halt_fault got=%b exp=0", Fault); end
      checks++; if (Commit !== 1'b0) begin failures++; $display("FAIL halt_idle_commit got=%b exp=0", Commit); end
      step();
      checks++; if (Done !== 1'b1 || Prog_Ctr !== 10'd12) begin failures++; $display("FAIL halt_stay got done=%b pc=%0d exp done=1 pc=12", Done, Prog_Ctr); end
      checks++; if (CycleCnt !== CYC_W'(13)) begin failures++; $display("FAIL halt_cyc got=%0d exp=13", CycleCnt); end
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++; if (Prog_Ctr !== '0 || Done !== 1'b0 || CycleCnt !== '0) begin failures++; $display("FAIL halt_restart got pc=%0d done=%b cyc=%0d exp 0/0/0", Prog_Ctr, Done, CycleCnt); end
   endtask

   task automatic test_wrap_fault();
      restart_to(0);
      dut.u_lut.core[5] = 10'd1023;
      Jump = 1'b1; TargetIdx = 5'd5;
      step();
      clear_flags();
      #1;
      checks++; if (Prog_Ctr !== 10'd1023 || Fault !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL wrap_jump got pc=%0d fault=%b done=%b exp 1023/0/0", Prog_Ctr, Fault, Done); end
      checks++; if (Commit !== 1'b1) begin failures++; $display("FAIL wrap_commit got=%b exp=1", Commit); end
      step();
      checks++; if (Done !== 1'b1 || Fault !== 1'b1) begin failures++; $display("FAIL wrap_flags got done=%b fault=%b exp 1/1", Done, Fault); end
      checks++; if (Prog_Ctr !== 10'd1023) begin failures++; $display("FAIL wrap_pc got=%0d exp=1023", Prog_Ctr); end
      step();
      checks++; if (Prog_Ctr !== 10'd1023 || Done !== 1'b1) begin failures++; $display("FAIL wrap_hold got pc=%0d done=%b exp 1023/1", Prog_Ctr, Done); end
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++; if (Fault !== 1'b0 || Prog_Ctr !== '0) begin failures++; $display("FAIL wrap_restart got fault=%b pc=%0d exp 0/0", Fault, Prog_Ctr); end
   endtask

   task automatic test_saturate();
      restart_to(0);
      dut.cyc_q = 16'hFFFE;
      step();
      checks++; if (CycleCnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%0h exp=ffff", CycleCnt); end
      step();
      checks++; if (CycleCnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", CycleCnt); end
   endtask

   task automatic test_reset_memwait();
      restart_to(4);
      MemOp = 1'b1;
      step();
      MemOp = 1'b0;
      checks++; if (Prog_Ctr !== 10'd4 || Commit !== 1'b1) begin failures++; $display("FAIL rmw_wait got pc=%0d commit=%b exp 4/1", Prog_Ctr, Commit); end
      #2;
      Reset = 1'b1;
      #1;
      checks++; if (Prog_Ctr !== '0 || Commit !== 1'b0 || Done !== 1'b0 || Fault !== 1'b0 || CycleCnt !== '0) begin
         failures++;
         $display("FAIL rmw_async got pc=%0d commit=%b done=%b fault=%b cyc=%0d exp all 0", Prog_Ctr, Commit, Done, Fault, CycleCnt);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      Start = 1'b1;
      step();
      Start = 1'b0;
      checks++; if (Prog_Ctr !== '0) begin failures++; $display("FAIL rmw_resume0 got=%0d exp=0", Prog_Ctr); end
      step();
      checks++; if (Prog_Ctr !== 10'd1) begin failures++; $display("FAIL rmw_resume1 got=%0d exp=1", Prog_Ctr); end
   endtask

   task automatic test_random();
      bit exp_commit, adv;
      do_reset();
      m_mode = 0; m_pc = 0; m_left = 0; m_cyc = 0; m_done = 0; m_fault = 0;
      for (int i = 0; i < 2**LUT_W; i++) begin
         m_lut[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
         dut.u_lut.core[i] = PC_W'(m_lut[i]);
      end
      for (int n = 0; n < 800; n++) begin
         Start     = ($urandom_range(0, 3) == 0);
         Branch    = ($urandom_range(0, 3) == 0);
         Zero      = ($urandom_range(0, 1) == 0);
         Jump      = ($urandom_range(0, 7) == 0);
         MemOp     = ($urandom_range(0, 5) == 0);
         Halt      = ($urandom_range(0, 40) == 0);
         TargetIdx = LUT_W'($urandom);
         #1;
         // A running instruction retires unless it is a multi-cycle memory op just starting
         exp_commit = (m_mode == 1 && (Halt || !MemOp || MEM_LAT == 1)) || (m_mode == 2 && m_left == 1);
         checks++; if (Commit !== exp_commit) begin failures++; $display("FAIL rnd_commit cyc %0d got=%b exp=%b", n, Commit, exp_commit); end
         checks++; if (Prog_Ctr !== PC_W'(m_pc)) begin failures++; $display("FAIL rnd_pc cyc %0d got=%0d exp=%0d", n, Prog_Ctr, m_pc); end
         checks++; if (Done !== m_done || Fault !== m_fault) begin failures++; $display("FAIL rnd_flags cyc %0d got done=%b fault=%b exp %b/%b", n, Done, Fault, m_done, m_fault); end
         checks++; if (CycleCnt !== CYC_W'(m_cyc)) begin failures++; $display("FAIL rnd_cyc cyc %0d got=%0d exp=%0d", n, CycleCnt, m_cyc); end
         step();
         adv = 0;
         if (m_mode == 1 || m_mode == 2) m_cyc = (m_cyc < CYC_TOP) ? m_cyc + 1 : CYC_TOP;
         case (m_mode)
            0, 3: if (Start) begin m_mode = 1; m_pc = 0; m_cyc = 0; m_done = 0; m_fault = 0; end
            1: begin
               if (Halt) begin m_mode = 3; m_done = 1; end
               else if (MemOp && MEM_LAT > 1) begin m_mode = 2; m_left = MEM_LAT - 1; end
               else if (Jump || (Branch && Zero)) m_pc = m_lut[TargetIdx];
               else adv = 1;
            end
            default: begin
               if (m_left == 1) begin m_mode = 1; adv = 1; end
               else m_left--;
            end
         endcase
         if (adv) begin
            if (m_pc == PC_TOP) begin m_mode = 3; m_done = 1; m_fault = 1; end
            else m_pc++;
         end
      end
      clear_flags();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_memop();
      test_halt_restart();
      test_wrap_fault();
      test_saturate();
      test_reset_memwait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
